// File: rtl/vga_rx_decoder_if.sv
// Bundle of the VGA generator outputs observed by the decoder and the decoder's status outputs.
interface vga_rx_decoder_if;
  logic       hsync;
  logic       vsync;
  logic [2:0] red;
  logic [2:0] green;
  logic [1:0] blue;
  logic       locked;
  logic [1:0] sym;
  logic       sym_valid;
  logic       frame_err;
  logic [9:0] rx_hc;
  logic [9:0] rx_vc;

  modport master (
    output hsync, vsync, red, green, blue,
    input  locked, sym, sym_valid, frame_err, rx_hc, rx_vc
  );

  modport slave (
    input  hsync, vsync, red, green, blue,
    output locked, sym, sym_valid, frame_err, rx_hc, rx_vc
  );
endinterface

// File: rtl/vga_rx_decoder.sv
// Sink-side VGA decoder: recovers pixel position from sync edges, checks line and
// frame timing, and classifies every completed frame as one of four symbols.
module vga_rx_decoder #(
  parameter int HPIXELS  = 800,
  parameter int VLINES   = 521,
  parameter int HPULSE   = 96,
  parameter int VPULSE   = 2,
  parameter int HBP      = 144,
  parameter int HFP      = 784,
  parameter int VBP      = 31,
  parameter int VFP      = 511,
  parameter int RECT_RED = 25921,
  parameter int DIAM_RED = 278159
) (
  input logic             dclk,
  input logic             clr,
  vga_rx_decoder_if.slave vga
);

  localparam int AREA = (HFP - HBP) * (VFP - VBP);
  localparam int HCTR = HBP + (HFP - HBP) / 2;
  localparam int VCTR = VBP + (VFP - VBP) / 2;

  localparam logic [9:0] HPIXELS_W = 10'(HPIXELS);
  localparam logic [9:0] VLINES_W  = 10'(VLINES);
  localparam logic [9:0] HPULSE_W  = 10'(HPULSE);
  localparam logic [9:0] VPULSE_W  = 10'(VPULSE);
  localparam logic [9:0] HBP_W     = 10'(HBP);
  localparam logic [9:0] HFP_W     = 10'(HFP);
  localparam logic [9:0] VBP_W     = 10'(VBP);
  localparam logic [9:0] VFP_W     = 10'(VFP);
  localparam logic [9:0] HCTR_W    = 10'(HCTR);
  localparam logic [9:0] VCTR_W    = 10'(VCTR);

  localparam logic [7:0] RGB_RED = 8'b111_000_00;
  localparam logic [7:0] RGB_GRN = 8'b000_111_00;

  typedef enum logic [1:0] {HUNT, MEASURE, LOCKED} state_t;

  state_t      state_q;
  logic        hs_q, vs_q;
  logic [9:0]  h_q, v_q;
  logic        locked_q, sym_valid_q, frame_err_q, ctr_red_q;
  logic [1:0]  sym_q;
  logic [18:0] red_cnt_q, grn_cnt_q, oth_cnt_q;

  logic        hfall, hrise, vfall, vrise, tracking;
  logic [9:0]  h_cur, v_cur, h_d;
  logic [7:0]  rgb;
  logic        is_red, is_grn, active, timing_err;
  logic        red_inc, grn_inc, oth_inc;
  logic [18:0] red_cnt_d, grn_cnt_d, oth_cnt_d;
  logic        ctr_red_d;
  logic        frame_ok, sym_hit;
  logic [1:0]  sym_code;

  assign hfall    = hs_q & ~vga.hsync;
  assign hrise    = ~hs_q & vga.hsync;
  assign vfall    = vs_q & ~vga.vsync;
  assign vrise    = ~vs_q & vga.vsync;
  assign tracking = (state_q != HUNT);

  // vfall wins over a coincident hfall so the new frame starts on line 0
  assign h_cur = hfall ? 10'd0 : h_q;
  assign v_cur = vfall ? 10'd0 : (hfall ? v_q + 10'd1 : v_q);
  assign h_d   = (h_cur == 10'h3FF) ? 10'h3FF : h_cur + 10'd1;

  assign rgb    = {vga.red, vga.green, vga.blue};
  assign is_red = (rgb == RGB_RED);
  assign is_grn = (rgb == RGB_GRN);
  assign active = (v_cur >= VBP_W) && (v_cur < VFP_W) && (h_cur >= HBP_W) && (h_cur < HFP_W);

  assign timing_err = tracking &&
                      ((hfall && (h_q != HPIXELS_W)) ||
                       (hrise && (h_cur != HPULSE_W)) ||
                       (vrise && (v_cur != VPULSE_W)) ||
                       (vfall && ((v_q + 10'd1) != VLINES_W)));

  assign red_inc = tracking && active && is_red;
  assign grn_inc = tracking && active && is_grn;
  assign oth_inc = tracking && (active ? !(is_red || is_grn) : (rgb != 8'h00));

  // The vfall pixel already belongs to the new frame, so counting restarts from zero on it
  assign red_cnt_d = (vfall ? 19'd0 : red_cnt_q) + 19'(red_inc);
  assign grn_cnt_d = (vfall ? 19'd0 : grn_cnt_q) + 19'(grn_inc);
  assign oth_cnt_d = (vfall ? 19'd0 : oth_cnt_q) + 19'(oth_inc);

  always_comb begin
    ctr_red_d = vfall ? 1'b0 : ctr_red_q;
    if (tracking && (h_cur == HCTR_W) && (v_cur == VCTR_W)) begin
      ctr_red_d = is_red;
    end
  end

  assign frame_ok = (oth_cnt_q == 19'd0) &&
                    (({1'b0, red_cnt_q} + {1'b0, grn_cnt_q}) == 20'(AREA));

  always_comb begin
    sym_hit  = 1'b0;
    sym_code = 2'd0;
    if (frame_ok) begin
      if (red_cnt_q == 19'd0) begin
        sym_hit  = 1'b1;
        sym_code = 2'd0;
      end else if (grn_cnt_q == 19'd0) begin
        sym_hit  = 1'b1;
        sym_code = 2'd2;
      end else if ((red_cnt_q == 19'(RECT_RED)) && ctr_red_q) begin
        sym_hit  = 1'b1;
        sym_code = 2'd1;
      end else if ((red_cnt_q == 19'(DIAM_RED)) && !ctr_red_q) begin
        sym_hit  = 1'b1;
        sym_code = 2'd3;
      end
    end
  end

  // A content failure leaves lock intact; only timing violations drop back to HUNT
  always_ff @(posedge dclk) begin
    if (clr) begin
      state_q     <= HUNT;
      hs_q        <= 1'b1;
      vs_q        <= 1'b1;
      h_q         <= 10'd0;
      v_q         <= 10'd0;
      locked_q    <= 1'b0;
      sym_q       <= 2'd0;
      sym_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      ctr_red_q   <= 1'b0;
      red_cnt_q   <= 19'd0;
      grn_cnt_q   <= 19'd0;
      oth_cnt_q   <= 19'd0;
    end else begin
      hs_q        <= vga.hsync;
      vs_q        <= vga.vsync;
      h_q         <= h_d;
      v_q         <= v_cur;
      ctr_red_q   <= ctr_red_d;
      red_cnt_q   <= red_cnt_d;
      grn_cnt_q   <= grn_cnt_d;
      oth_cnt_q   <= oth_cnt_d;
      sym_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      case (state_q)
        HUNT: begin
          if (vfall) begin
            state_q <= MEASURE;
          end
        end
        MEASURE, LOCKED: begin
          if (timing_err) begin
            frame_err_q <= 1'b1;
            locked_q    <= 1'b0;
            state_q     <= HUNT;
          end else if (vfall) begin
            state_q  <= LOCKED;
            locked_q <= 1'b1;
            if (sym_hit) begin
              sym_q       <= sym_code;
              sym_valid_q <= 1'b1;
            end else begin
              frame_err_q <= 1'b1;
            end
          end
        end
        default: state_q <= HUNT;
      endcase
    end
  end

  assign vga.locked    = locked_q;
  assign vga.sym       = sym_q;
  assign vga.sym_valid = sym_valid_q;
  assign vga.frame_err = frame_err_q;
  assign vga.rx_hc     = tracking ? h_cur : 10'd0;
  assign vga.rx_vc     = tracking ? v_cur : 10'd0;

endmodule

// File: tb/tb_vga_rx_decoder.sv
// Bench for vga_rx_decoder on a shrunken raster: a generator model drives frames and
// the expected per-frame outcomes are queued and matched against the decoder's pulses.
module tb_vga_rx_decoder;

  localparam int HP  = 40;
  localparam int VL  = 30;
  localparam int HPU = 4;
  localparam int VPU = 2;
  localparam int HB  = 8;
  localparam int HF  = 36;
  localparam int VB  = 4;
  localparam int VF  = 26;
  localparam int CX  = 22;
  localparam int CY  = 15;
  localparam int RR  = 5;
  localparam int DR  = 6;
  // Rectangle: 11x11 red. Diamond: 2*6*6+2*6+1 = 85 green out of 28*22 = 616.
  localparam int RECT = 121;
  localparam int DIAM = 531;

  localparam logic [7:0] RED   = 8'b111_000_00;
  localparam logic [7:0] GREEN = 8'b000_111_00;

  typedef enum {M_HUNT, M_MEAS, M_LOCK} mode_t;

  typedef struct {
    int         cyc;
    logic       sv;
    logic       fe;
    logic [1:0] sym;
    logic       lock;
  } event_t;

  logic dclk = 1'b0;
  logic clr;
  vga_rx_decoder_if vga();

  event_t     expQ[$];
  int         testsRun = 0;
  int         testsFailed = 0;
  int         cycleNum = 0;
  mode_t      mode = M_HUNT;
  logic [1:0] lastSym = 2'd0;
  int         frameSym = 0;
  logic       frameBad = 1'b0;

  always #5 dclk = ~dclk;

  vga_rx_decoder #(
    .HPIXELS(HP), .VLINES(VL), .HPULSE(HPU), .VPULSE(VPU),
    .HBP(HB), .HFP(HF), .VBP(VB), .VFP(VF),
    .RECT_RED(RECT), .DIAM_RED(DIAM)
  ) dut (
    .dclk(dclk),
    .clr (clr),
    .vga (vga)
  );

  function automatic logic [7:0] pixelColour(input int s, input int hc, input int vc);
    int adx, ady;
    if (hc < HB || hc >= HF || vc < VB || vc >= VF) return 8'h00;
    adx = (hc >= CX) ? hc - CX : CX - hc;
    ady = (vc >= CY) ? vc - CY : CY - vc;
    case (s)
      0:       return GREEN;
      2:       return RED;
      1:       return (adx <= RR && ady <= RR) ? RED : GREEN;
      default: return (adx + ady <= DR) ? GREEN : RED;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s at cycle %0d: got %0d, wanted %0d", tag, cycleNum, actual, expected);
    end
  endtask

  task automatic pushEvent(input logic sv, input logic fe, input logic [1:0] sym, input logic lock);
    event_t e;
    e.cyc  = cycleNum;
    e.sv   = sv;
    e.fe   = fe;
    e.sym  = sym;
    e.lock = lock;
    expQ.push_back(e);
  endtask

  // Drives one pixel, samples mid-cycle, then advances to just after the next rising edge
  task automatic applyStimulus(input logic [7:0] rgb, input logic hs, input logic vs,
                               input logic rst, input int hc, input int vc);
    event_t e;
    clr       = rst;
    vga.hsync = hs;
    vga.vsync = vs;
    vga.red   = rgb[7:5];
    vga.green = rgb[4:2];
    vga.blue  = rgb[1:0];
    #3;
    checkOutput("rx_hc", vga.rx_hc, (mode == M_HUNT) ? 0 : hc);
    checkOutput("rx_vc", vga.rx_vc, (mode == M_HUNT) ? 0 : vc);
    if (expQ.size() > 0 && expQ[0].cyc == cycleNum) begin
      e = expQ.pop_front();
      checkOutput("sym_valid", vga.sym_valid, e.sv);
      checkOutput("frame_err", vga.frame_err, e.fe);
      checkOutput("sym", vga.sym, e.sym);
      checkOutput("locked", vga.locked, e.lock);
    end else begin
      checkOutput("idle_pulses", {vga.sym_valid, vga.frame_err}, 2'b00);
    end
    @(posedge dclk);
    #1;
    cycleNum++;
  endtask

  task automatic runFrame(input int s, input int stretchLine, input int badH, input int badV,
                          input int clrH, input int clrV);
    int         len;
    logic [7:0] rgb;
    logic       doClr;
    for (int vc = 0; vc < VL; vc++) begin
      len = (vc == stretchLine) ? HP + 1 : HP;
      for (int hc = 0; hc < len; hc++) begin
        rgb   = pixelColour(s, hc, vc);
        doClr = (hc == clrH && vc == clrV);
        if (hc == badH && vc == badV) rgb[1:0] = 2'b01;
        applyStimulus(rgb, hc >= HPU, vc >= VPU, doClr, hc, vc);
        if (doClr) begin
          pushEvent(1'b0, 1'b0, 2'd0, 1'b0);
          mode    = M_HUNT;
          lastSym = 2'd0;
        end else if (hc == 0 && vc == 0) begin
          if (mode == M_HUNT) begin
            mode = M_MEAS;
          end else begin
            if (frameBad) begin
              pushEvent(1'b0, 1'b1, lastSym, 1'b1);
            end else begin
              lastSym = 2'(frameSym);
              pushEvent(1'b1, 1'b0, lastSym, 1'b1);
            end
            mode = M_LOCK;
          end
          frameSym = s;
          frameBad = (badH >= 0);
        end else if (stretchLine >= 0 && hc == 0 && vc == stretchLine + 1 && mode != M_HUNT) begin
          pushEvent(1'b0, 1'b1, lastSym, 1'b0);
          mode = M_HUNT;
        end
      end
    end
  endtask

  initial begin
    clr       = 1'b1;
    vga.hsync = 1'b1;
    vga.vsync = 1'b1;
    vga.red   = 3'd0;
    vga.green = 3'd0;
    vga.blue  = 2'd0;
    repeat (3) @(posedge dclk);
    #1;
    clr = 1'b0;
    #3;
    checkOutput("reset_locked", vga.locked, 0);
    checkOutput("reset_sym", vga.sym, 0);
    checkOutput("reset_sym_valid", vga.sym_valid, 0);
    checkOutput("reset_frame_err", vga.frame_err, 0);
    checkOutput("reset_rx_hc", vga.rx_hc, 0);
    checkOutput("reset_rx_vc", vga.rx_vc, 0);
    @(posedge dclk);
    #1;

    runFrame(0, -1, -1, -1, -1, -1);
    runFrame(0, -1, -1, -1, -1, -1);
    runFrame(1, -1, -1, -1, -1, -1);
    runFrame(3, -1, -1, -1, -1, -1);
    runFrame(2, -1, -1, -1, -1, -1);
    runFrame(2, 10, -1, -1, -1, -1);
    runFrame(1, -1, -1, -1, -1, -1);
    runFrame(1, -1, 20, 10, -1, -1);
    runFrame(3, -1, -1, -1, 12, 20);
    runFrame(3, -1, -1, -1, -1, -1);
    runFrame(0, -1, -1, -1, -1, -1);
    runFrame(0, -1, -1, -1, -1, -1);
    runFrame(0, -1, -1, -1, -1, -1);

    checkOutput("events_outstanding", expQ.size(), 0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
